// File: rtl/vnp4_port_pkg.sv
// Shared VNP4 stream widths, port numbering and ingress/egress port mapping.
package vnp4_port_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned KEEP_W = 64;
  localparam int unsigned USER_W = 16;
  localparam int unsigned PORT_W = 4;

  localparam logic [PORT_W-1:0] PORT_QDMA_BASE = 4'd0;
  localparam logic [PORT_W-1:0] PORT_CMAC_BASE = 4'd8;
  localparam logic [PORT_W-1:0] PORT_NONE      = 4'hF;

  typedef enum logic [0:0] {StIdle, StPkt} merge_state_e;

  // Source index -> port number. PF sources come first (QDMA-major), CMAC sources follow.
  function automatic logic [PORT_W-1:0] encode_port(input int unsigned idx,
                                                    input int unsigned num_phys_func,
                                                    input int unsigned num_pf_src);
    int unsigned qdma;
    int unsigned pf;
    if (idx < num_pf_src) begin
      qdma = idx / num_phys_func;
      pf   = idx % num_phys_func;
      return PORT_QDMA_BASE + PORT_W'(4 * qdma + pf);
    end
    return PORT_CMAC_BASE + PORT_W'(idx - num_pf_src);
  endfunction

  // Port number -> source index, used by egress_switch.
  function automatic int unsigned decode_port(input logic [PORT_W-1:0] port,
                                              input int unsigned num_phys_func,
                                              input int unsigned num_qdma);
    if (port >= PORT_CMAC_BASE) begin
      return num_qdma * num_phys_func + 32'(port - PORT_CMAC_BASE);
    end
    return (32'(port) / 4) * num_phys_func + 32'(port) % 4;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Host/CMAC side AXI stream with source/destination/size sideband.
interface axi_stream_if;
  import vnp4_port_pkg::*;

  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;
  logic              valid;
  logic              ready;
  logic [USER_W-1:0] user_size;
  logic [USER_W-1:0] user_src;
  logic [USER_W-1:0] user_dst;

  modport master (output data, keep, last, valid, user_size, user_src, user_dst, input ready);
  modport slave  (input data, keep, last, valid, user_size, user_src, user_dst, output ready);
endinterface

// File: rtl/axi_stream_vnp4_if.sv
// VNP4 pipeline stream: first beat of a packet carries port/size metadata.
interface axi_stream_vnp4_if;
  import vnp4_port_pkg::*;

  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              last;
  logic              valid;
  logic              ready;
  logic              user_valid;
  logic [USER_W-1:0] user_ingress_port;
  logic [USER_W-1:0] user_egress_port;
  logic [USER_W-1:0] user_size;

  modport master (output data, keep, last, valid, user_valid, user_ingress_port,
                  user_egress_port, user_size, input ready);
  modport slave  (input data, keep, last, valid, user_valid, user_ingress_port,
                  user_egress_port, user_size, output ready);
endinterface

// File: rtl/axis_skid_reg.sv
// Two-entry skid register: full throughput, upstream ready is a pure register output.
module axis_skid_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [Width-1:0] main_q, main_d, skid_q, skid_d;
  logic             main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic             in_fire;

  assign in_ready  = ~skid_valid_q;
  assign in_fire   = in_valid & in_ready;
  assign out_data  = main_q;
  assign out_valid = main_valid_q;

  // Next state: refill the output entry from skid first, else from the input; park on stall.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = in_fire;
        if (in_fire) main_d = in_data;
      end
    end else if (in_fire) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule

// File: rtl/ingress_merge.sv
// Round-robin whole-packet merge of PF and CMAC streams into the VNP4 pipeline stream.
module ingress_merge
  import vnp4_port_pkg::*;
#(
  parameter int unsigned NUM_QDMA      = 1,
  parameter int unsigned NUM_PHYS_FUNC = 1,
  parameter int unsigned NUM_CMAC_PORT = 1
) (
  input logic               aclk,
  input logic               aresetn,
  axi_stream_if.slave       s_axis_pf [NUM_QDMA*NUM_PHYS_FUNC],
  axi_stream_if.slave       s_axis_cmac [NUM_CMAC_PORT],
  axi_stream_vnp4_if.master m_axis
);

  localparam int unsigned NumPf    = NUM_QDMA * NUM_PHYS_FUNC;
  localparam int unsigned NumSrc   = NumPf + NUM_CMAC_PORT;
  localparam int unsigned IdxW     = (NumSrc > 1) ? $clog2(NumSrc) : 1;
  localparam int unsigned PayloadW = DATA_W + KEEP_W + 2 + 3 * USER_W;
  localparam logic [IdxW:0] NumSrcW = (IdxW + 1)'(NumSrc);

  logic [NumSrc-1:0] src_valid, src_last, src_ready;
  logic [DATA_W-1:0] src_data [NumSrc];
  logic [KEEP_W-1:0] src_keep [NumSrc];
  logic [USER_W-1:0] src_size [NumSrc];
  logic [PORT_W-1:0] port_lut [NumSrc];

  for (genvar i = 0; i < NumPf; i++) begin : g_pf
    logic unused_pf_user;
    assign src_valid[i]       = s_axis_pf[i].valid;
    assign src_last[i]        = s_axis_pf[i].last;
    assign src_data[i]        = s_axis_pf[i].data;
    assign src_keep[i]        = s_axis_pf[i].keep;
    assign src_size[i]        = s_axis_pf[i].user_size;
    assign s_axis_pf[i].ready = src_ready[i];
    assign port_lut[i]        = encode_port(i, NUM_PHYS_FUNC, NumPf);
    assign unused_pf_user     = ^{s_axis_pf[i].user_src, s_axis_pf[i].user_dst};
  end

  for (genvar c = 0; c < NUM_CMAC_PORT; c++) begin : g_cmac
    logic unused_cmac_user;
    assign src_valid[NumPf+c]   = s_axis_cmac[c].valid;
    assign src_last[NumPf+c]    = s_axis_cmac[c].last;
    assign src_data[NumPf+c]    = s_axis_cmac[c].data;
    assign src_keep[NumPf+c]    = s_axis_cmac[c].keep;
    assign src_size[NumPf+c]    = s_axis_cmac[c].user_size;
    assign s_axis_cmac[c].ready = src_ready[NumPf+c];
    assign port_lut[NumPf+c]    = encode_port(NumPf + c, NUM_PHYS_FUNC, NumPf);
    assign unused_cmac_user     = ^{s_axis_cmac[c].user_src, s_axis_cmac[c].user_dst};
  end

  merge_state_e      state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick_idx;
  logic              first_q, first_d, pick_found;
  logic [IdxW:0]     cand, grant_inc;
  logic              in_valid, in_ready, out_valid;
  logic              meta_valid;
  logic [USER_W-1:0] meta_ing, meta_egr, meta_size;
  logic [PayloadW-1:0] in_payload, out_payload;

  assign grant_inc = {1'b0, grant_q} + (IdxW + 1)'(1);

  // First valid source at or after rr_ptr, wrapping modulo NumSrc.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NumSrc; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
      if (cand >= NumSrcW) cand = cand - NumSrcW;
      if (!pick_found && src_valid[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Packet FSM: grant in idle, forward the granted source until its last beat.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    first_d   = first_q;
    src_ready = '0;
    in_valid  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick_idx;
          first_d = 1'b1;
          state_d = StPkt;
        end
      end
      StPkt: begin
        in_valid           = src_valid[grant_q] & aresetn;
        src_ready[grant_q] = in_ready & aresetn;
        if (in_valid && in_ready) begin
          first_d = 1'b0;
          if (src_last[grant_q]) begin
            rr_ptr_d = (grant_inc == NumSrcW) ? '0 : grant_inc[IdxW-1:0];
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Metadata only on the first beat; zeros elsewhere.
  always_comb begin
    meta_valid = 1'b0;
    meta_ing   = '0;
    meta_egr   = '0;
    meta_size  = '0;
    if (first_q) begin
      meta_valid = 1'b1;
      meta_ing   = USER_W'(port_lut[grant_q]);
      meta_egr   = USER_W'(PORT_NONE);
      meta_size  = src_size[grant_q];
    end
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      first_q  <= first_d;
    end
  end

  assign in_payload = {src_data[grant_q], src_keep[grant_q], src_last[grant_q],
                       meta_valid, meta_ing, meta_egr, meta_size};

  axis_skid_reg #(
    .Width(PayloadW)
  ) u_out_stage (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in_data  (in_payload),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_payload),
    .out_valid(out_valid),
    .out_ready(m_axis.ready)
  );

  assign m_axis.valid = out_valid;
  assign {m_axis.data, m_axis.keep, m_axis.last, m_axis.user_valid, m_axis.user_ingress_port,
          m_axis.user_egress_port, m_axis.user_size} = out_payload;

endmodule

// File: tb/tb_ingress_merge.sv
// Directed bench for ingress_merge with 2 QDMA x 4 PF + 2 CMAC sources.
module tb_ingress_merge;
  localparam int NQ = 2, NPF = 4, NC = 2, NPFS = 8, NSRC = 10;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic m_ready = 1'b1;
  always #5 aclk = ~aclk;

  logic         src_valid [NSRC];
  logic         src_last  [NSRC];
  logic         src_ready [NSRC];
  logic [511:0] src_data  [NSRC];
  logic [15:0]  src_size  [NSRC];

  axi_stream_if      pf_if [NPFS] ();
  axi_stream_if      cmac_if [NC] ();
  axi_stream_vnp4_if m_if ();

  for (genvar g = 0; g < NPFS; g++) begin : g_pf_drv
    assign pf_if[g].valid     = src_valid[g];
    assign pf_if[g].last      = src_last[g];
    assign pf_if[g].data      = src_data[g];
    assign pf_if[g].keep      = '1;
    assign pf_if[g].user_size = src_size[g];
    assign pf_if[g].user_src  = 16'hA5A5;
    assign pf_if[g].user_dst  = 16'h5A5A;
    assign src_ready[g]       = pf_if[g].ready;
  end
  for (genvar g = 0; g < NC; g++) begin : g_cmac_drv
    assign cmac_if[g].valid     = src_valid[NPFS+g];
    assign cmac_if[g].last      = src_last[NPFS+g];
    assign cmac_if[g].data      = src_data[NPFS+g];
    assign cmac_if[g].keep      = '1;
    assign cmac_if[g].user_size = src_size[NPFS+g];
    assign cmac_if[g].user_src  = 16'h1234;
    assign cmac_if[g].user_dst  = 16'h4321;
    assign src_ready[NPFS+g]    = cmac_if[g].ready;
  end
  assign m_if.ready = m_ready;

  ingress_merge #(
    .NUM_QDMA     (NQ),
    .NUM_PHYS_FUNC(NPF),
    .NUM_CMAC_PORT(NC)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .s_axis_pf  (pf_if),
    .s_axis_cmac(cmac_if),
    .m_axis     (m_if)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rst_cnt = 0;
  bit toggle = 0;

  // Per-source packet program.
  int pkts [NSRC], nbeats [NSRC], size_a [NSRC], beat [NSRC], pkt [NSRC];
  int gap_after [NSRC], gap_len [NSRC], gap_cnt [NSRC], kill_after [NSRC];

  // Logs of accepted output beats and source handshakes.
  logic [63:0] out_data [$];
  bit          out_last [$], out_uv [$], out_clean [$];
  int          out_ing [$], out_egr [$], out_size [$], out_cyc [$];
  int          acc_cyc [$];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NSRC; i++) begin
      src_valid[i] = (pkts[i] > 0) && (gap_cnt[i] == 0);
      src_last[i]  = (beat[i] == nbeats[i] - 1);
      src_data[i]  = {480'd0, 8'(i), 8'(pkt[i]), 16'(beat[i])};
      src_size[i]  = 16'(size_a[i]);
    end
  endtask

  task automatic arm(int s, int np, int nb, int sz, int ga, int gl, int ka);
    pkts[s] = np; nbeats[s] = nb; size_a[s] = sz; beat[s] = 0; pkt[s] = 0;
    gap_after[s] = ga; gap_len[s] = gl; gap_cnt[s] = 0; kill_after[s] = ka;
  endtask

  task automatic clear_logs();
    out_data.delete(); out_last.delete(); out_uv.delete(); out_clean.delete();
    out_ing.delete(); out_egr.delete(); out_size.delete(); out_cyc.delete();
    acc_cyc.delete();
  endtask

  // Single driver/monitor loop: sample at negedge, drive #1 after posedge.
  task automatic run(input int budget);
    int idle, n;
    bit stall_prev, busy, done;
    logic [63:0] held;
    bit acc [NSRC];
    idle = 0; n = 0; stall_prev = 0; done = 0; held = '0;
    while (!done) begin
      @(negedge aclk);
      if (rst_cnt == 1) begin
        bit any_rdy;
        any_rdy = 0;
        for (int i = 0; i < NSRC; i++) any_rdy |= src_ready[i];
        check_eq("rst_mid_valid", 64'(m_if.valid), 64'd0);
        check_eq("rst_mid_ready", 64'(any_rdy), 64'd0);
      end
      if (rst_cnt > 0) rst_cnt--;
      if (stall_prev) begin
        check_eq("hold_valid", 64'(m_if.valid), 64'd1);
        check_eq("hold_data", m_if.data[63:0], held);
      end
      stall_prev = m_if.valid && !m_ready;
      held = m_if.data[63:0];
      if (m_if.valid && m_ready) begin
        out_data.push_back(m_if.data[63:0]);
        out_clean.push_back((m_if.data[511:64] == '0) && (m_if.keep == '1));
        out_last.push_back(m_if.last);
        out_uv.push_back(m_if.user_valid);
        out_ing.push_back(int'(m_if.user_ingress_port));
        out_egr.push_back(int'(m_if.user_egress_port));
        out_size.push_back(int'(m_if.user_size));
        out_cyc.push_back(cyc);
        idle = 0;
      end else begin
        idle++;
      end
      for (int i = 0; i < NSRC; i++) begin
        acc[i] = src_valid[i] && src_ready[i];
        if (acc[i]) acc_cyc.push_back(cyc);
      end
      @(posedge aclk);
      #1;
      cyc++;
      aresetn = 1'b1;
      for (int i = 0; i < NSRC; i++) begin
        if (acc[i]) begin
          if (kill_after[i] == beat[i]) begin
            aresetn = 1'b0;
            pkts[i] = 0;
            rst_cnt = 2;
          end else begin
            if (gap_after[i] == beat[i]) gap_cnt[i] = gap_len[i];
            if (beat[i] == nbeats[i] - 1) begin
              beat[i] = 0; pkt[i]++; pkts[i]--;
            end else begin
              beat[i]++;
            end
          end
        end else if (gap_cnt[i] > 0) begin
          gap_cnt[i]--;
        end
      end
      m_ready = toggle ? ~m_ready : 1'b1;
      drive();
      n++;
      busy = 0;
      for (int i = 0; i < NSRC; i++) if (pkts[i] > 0) busy = 1;
      if (!busy && idle >= 6) done = 1;
      if (n >= budget) begin
        check_eq("timeout_busy", 64'(busy), 64'd0);
        done = 1;
      end
    end
  endtask

  task automatic exp_beat(string t, int k, int s, int pk, int bt, bit lst, bit first);
    check_eq({t, "_count"}, 64'(out_data.size() > k), 64'd1);
    if (out_data.size() <= k) return;
    check_eq({t, "_data"}, out_data[k], 64'({8'(s), 8'(pk), 16'(bt)}));
    check_eq({t, "_clean"}, 64'(out_clean[k]), 64'd1);
    check_eq({t, "_last"}, 64'(out_last[k]), 64'(lst));
    check_eq({t, "_uv"}, 64'(out_uv[k]), 64'(first));
    check_eq({t, "_ing"}, 64'(out_ing[k]), first ? 64'(first_port(s)) : 64'd0);
    check_eq({t, "_egr"}, 64'(out_egr[k]), first ? 64'h000F : 64'd0);
    check_eq({t, "_size"}, 64'(out_size[k]), first ? 64'(size_a[s]) : 64'd0);
  endtask

  // Hand table of expected ingress port per source index.
  function automatic int first_port(int s);
    int lut [NSRC];
    lut = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    return lut[s];
  endfunction

  initial begin
    for (int i = 0; i < NSRC; i++) arm(i, 0, 1, 0, -1, 0, -1);
    drive();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    begin
      bit any_rdy;
      any_rdy = 0;
      for (int i = 0; i < NSRC; i++) any_rdy |= src_ready[i];
      check_eq("reset_valid", 64'(m_if.valid), 64'd0);
      check_eq("reset_last", 64'(m_if.last), 64'd0);
      check_eq("reset_uv", 64'(m_if.user_valid), 64'd0);
      check_eq("reset_data", m_if.data[63:0], 64'd0);
      check_eq("reset_user", 64'({m_if.user_ingress_port, m_if.user_egress_port,
                                  m_if.user_size}), 64'd0);
      check_eq("reset_ready", 64'(any_rdy), 64'd0);
    end
    @(posedge aclk);
    #1 aresetn = 1'b1;

    // Single PF0 3-beat packet.
    clear_logs();
    arm(0, 1, 3, 150, -1, 0, -1);
    drive();
    run(200);
    check_eq("t1_nbeats", 64'(out_data.size()), 64'd3);
    for (int b = 0; b < 3; b++) exp_beat($sformatf("t1_b%0d", b), b, 0, 0, b, b == 2, b == 0);
    if (out_cyc.size() > 0 && acc_cyc.size() > 0)
      check_eq("t1_latency", 64'(out_cyc[0] - acc_cyc[0]), 64'd1);

    // QDMA1 PF2 and CMAC1 single-beat packets.
    clear_logs();
    arm(6, 1, 1, 64, -1, 0, -1);
    arm(9, 1, 1, 65, -1, 0, -1);
    drive();
    run(200);
    check_eq("t2_nbeats", 64'(out_data.size()), 64'd2);
    exp_beat("t2_q1pf2", 0, 6, 0, 0, 1, 1);
    exp_beat("t2_cmac1", 1, 9, 0, 0, 1, 1);

    // PF0 and CMAC0 continuously valid: packets alternate 0,8,0,8.
    clear_logs();
    arm(0, 2, 2, 100, -1, 0, -1);
    arm(8, 2, 2, 200, -1, 0, -1);
    drive();
    run(300);
    check_eq("t3_nbeats", 64'(out_data.size()), 64'd8);
    for (int p = 0; p < 4; p++) begin
      exp_beat($sformatf("t3_p%0d_b0", p), 2 * p, (p % 2) ? 8 : 0, p / 2, 0, 0, 1);
      exp_beat($sformatf("t3_p%0d_b1", p), 2 * p + 1, (p % 2) ? 8 : 0, p / 2, 1, 1, 0);
    end

    // 8-beat packet from PF3 with output ready toggling every cycle.
    clear_logs();
    toggle = 1;
    arm(3, 1, 8, 512, -1, 0, -1);
    drive();
    run(300);
    toggle = 0;
    m_ready = 1'b1;
    check_eq("t4_nbeats", 64'(out_data.size()), 64'd8);
    for (int b = 0; b < 8; b++) exp_beat($sformatf("t4_b%0d", b), b, 3, 0, b, b == 7, b == 0);

    // Reset pulse after beat 2 of a 5-beat packet from QDMA1 PF1.
    clear_logs();
    arm(5, 1, 5, 320, -1, 0, 1);
    drive();
    run(200);
    check_eq("t5_no_tail", 64'(out_data.size()), 64'd2);
    exp_beat("t5_b0", 0, 5, 0, 0, 0, 1);
    exp_beat("t5_b1", 1, 5, 0, 1, 0, 0);
    clear_logs();
    arm(1, 1, 2, 77, -1, 0, -1);
    drive();
    run(200);
    check_eq("t5_post_nbeats", 64'(out_data.size()), 64'd2);
    exp_beat("t5_post_b0", 0, 1, 0, 0, 0, 1);
    exp_beat("t5_post_b1", 1, 1, 0, 1, 1, 0);

    // PF2 drops valid for 3 cycles mid-packet while PF7 waits.
    clear_logs();
    arm(2, 1, 4, 90, 1, 3, -1);
    arm(7, 1, 2, 91, -1, 0, -1);
    drive();
    run(300);
    check_eq("t6_nbeats", 64'(out_data.size()), 64'd6);
    for (int b = 0; b < 4; b++) exp_beat($sformatf("t6_a%0d", b), b, 2, 0, b, b == 3, b == 0);
    exp_beat("t6_b0", 4, 7, 0, 0, 0, 1);
    exp_beat("t6_b1", 5, 7, 0, 1, 1, 0);
    if (out_cyc.size() >= 3) check_eq("t6_gap", 64'(out_cyc[2] - out_cyc[1] >= 4), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ingress_merge.md
# ingress_merge

Merges the per-PF QDMA host streams and the CMAC RX streams into the single VNP4 stream that feeds the P4 pipeline. It is the upstream counterpart of egress_switch. It arbitrates whole packets round-robin and encodes each source's fixed position into a 4-bit ingress port number. It attaches that port number plus the packet size as first-beat metadata.

## Interface
- NUM_QDMA, 1, QDMA instances (1..2)
- NUM_PHYS_FUNC, 1, physical functions per QDMA (1..4)
- NUM_CMAC_PORT, 1, CMAC ports (1..2)
- aclk  input  1  clock
- aresetn  input  1  reset, synchronous, active-low
- s_axis_pf  axi_stream_if.slave  array [NUM_QDMA*NUM_PHYS_FUNC]  host TX streams; element x*NUM_PHYS_FUNC+y is QDMA x, PF y
- s_axis_cmac  axi_stream_if.slave  array [NUM_CMAC_PORT]  CMAC RX streams
- m_axis  axi_stream_vnp4_if.master  1  merged stream to the P4 pipeline
  - data 512 bits, keep 64 bits
  - last, valid, ready
  - user_valid, user_ingress_port, user_egress_port, user_size 16 bits

## Operation
- Sources are numbered N = NUM_QDMA*NUM_PHYS_FUNC + NUM_CMAC_PORT. PF sources take indices 0..; CMAC sources follow.
- Port encoding (inverse of egress decode):
  - QDMA x, PF y → 4*x + y
  - CMAC c → 8 + c
  - Value is zero-extended to the interface field width.
- FSM has two states, IDLE and PKT.
  - IDLE: if any source valid is high, register grant = first valid source at or after rr_ptr (wrapping modulo N), then go to PKT. If no source is valid, stay in IDLE.
  - PKT: s_axis ready of the granted source = output stage can accept. All other source ready signals are 0. A handshake on a beat with last=1 sets rr_ptr = (grant+1) mod N and returns the FSM to IDLE.
- First-beat flag:
  - Set on entry to PKT; cleared by the first accepted beat.
  - The output beat carrying the flag drives the following metadata:
    - user_valid = 1
    - user_ingress_port = encoded grant
    - user_size = source user_size of that beat
    - user_egress_port = all ones (4'hF, zero-extended), meaning undecided
  - On all later beats, user_valid = 0 and the other user fields are 0.
- Source user_src and user_dst are ignored.
- data, keep and last pass through unmodified. keep is not checked.
- A single-beat packet drives user_valid=1 and last=1 on the same output beat.

## Timing
- Output stage is a 2-entry skid register: full throughput with no combinational path from m_axis.ready to source ready.
- Latency: source beat accepted in cycle t appears on m_axis in cycle t+1.
- Grant happens one cycle after IDLE sees valid, so the first beat of a packet is accepted no earlier than that cycle + 1.
- Exactly one idle cycle on the source side between consecutive packets, including packets back-to-back from the same source.
- m_axis.valid, once asserted, holds with stable data until m_axis.ready is high.
- Source valid dropping mid-packet inserts bubbles only; grant is held until last.
- Reset values: m_axis.valid/last/user_valid 0; data, keep and user fields 0; all source ready 0; FSM IDLE; rr_ptr 0; skid buffer empty.
- Reset mid-packet discards the partial packet in the skid buffer; no tail is emitted after reset.
- Full output stage (ready low) deasserts the granted source ready in the same cycle the second skid entry fills.

## Structure
- vnp4_port_pkg holds:
  - port number constants (PORT_QDMA_BASE=0, PORT_CMAC_BASE=8, PORT_NONE=4'hF)
  - function encode_port(source index, NUM_PHYS_FUNC)
  - the 16-bit user field width
- The egress decode function belongs in the same package.
- Sub-module axis_skid_reg (parameterised payload width) implements the output stage. It is reusable on the egress side.

## Test plan
- Single PF0 3-beat packet, user_size=150, m_axis.ready=1 → 3 output beats starting 1 cycle after the first handshake. Beat 1 has user_valid=1, ingress_port=0, size=150, egress_port=4'hF; later beats have user_valid=0.
- NUM_QDMA=2, NUM_PHYS_FUNC=4, NUM_CMAC_PORT=2; one 1-beat packet from each of QDMA1 PF2 and CMAC1 → ingress_port 6 then 9. Each beat has last=1 and user_valid=1.
- PF0 and CMAC0 continuously valid, 2-beat packets → output alternates 0,8,0,8, with no source served twice consecutively.
- m_axis.ready toggling 1-0-1 every cycle during an 8-beat packet → all 8 beats delivered in order with no duplication or loss, and data stable while ready=0.
- aresetn low for 1 cycle after beat 2 of a 5-beat packet → valid=0 next cycle and all ready=0. After reset, a new packet from source 1 emits user_valid=1 on its first beat.
- Source valid deasserted for 3 cycles mid-packet while a second source is valid → no interleaving. The second source is granted only after the first packet's last beat.
